// File: rtl/phy_tx_pkg.sv
// Shared constants, FSM state type and lane-priority helper for the transmit
// lane serializer.
package phy_tx_pkg;
    localparam logic [7:0] COM_SYM   = 8'hBC;
    localparam int         MAX_LANES = 32;

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } lane_sel_t;

    function automatic int lane_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Lowest set bit of mask at index >= from; found is clear when none exists.
    function automatic lane_sel_t next_set_bit(input logic [MAX_LANES-1:0] mask, input int from);
        lane_sel_t sel;
        sel = '0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                sel.found = 1'b1;
                sel.idx   = 5'(i);
            end
        end
        return sel;
    endfunction
endpackage

// File: rtl/phy_tx_word_fifo.sv
// Word FIFO holding {lane mask, lane data}; exposes the head entry and the
// entry behind it so the serializer can start the next word without a bubble.
module phy_tx_word_fifo #(
    parameter  int WIDTH = 36,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [WIDTH-1:0] o_next,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    w_rd_ptr_nx;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign w_rd_ptr_nx = r_rd_ptr + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= w_rd_ptr_nx;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; occupancy lives in the pointers/count, so stale entries are never treated as data.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_next  = r_mem[w_rd_ptr_nx];
    assign o_count = r_count;
endmodule

// File: rtl/phy_tx_lane_serializer.sv
// Buffers parallel lane words and emits their valid bytes one per cycle in
// ascending lane order, filling with IDLE_SYM when enabled and nothing is pending.
module phy_tx_lane_serializer
    import phy_tx_pkg::*;
#(
    parameter  int                NUM_LANES = 4,
    parameter  int                DATA_W    = 8,
    parameter  int                DEPTH     = 4,
    parameter  logic [DATA_W-1:0] IDLE_SYM  = DATA_W'(COM_SYM),
    localparam int                LW        = lane_w(NUM_LANES),
    localparam int                CW        = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_LANES*DATA_W-1:0] in_data,
    input  logic [NUM_LANES-1:0]        in_valid,
    output logic                        in_ready,
    input  logic                        idle_en,
    output logic [DATA_W-1:0]           out_data,
    output logic [LW-1:0]               out_lane,
    output logic                        out_valid,
    output logic                        out_idle,
    input  logic                        out_ready,
    output logic [CW-1:0]               fifo_count
);
    localparam int EW = NUM_LANES * (DATA_W + 1);

    logic [EW-1:0]        w_head, w_next;
    logic                 w_push, w_pop, w_full, w_empty, w_load;
    logic [MAX_LANES-1:0] w_head_mask, w_next_mask;
    logic [DATA_W-1:0]    w_head_lane [NUM_LANES];
    logic [DATA_W-1:0]    w_next_lane [NUM_LANES];
    lane_sel_t            w_sel_above, w_sel_head, w_sel_next;

    state_t               r_state, w_state_nx;
    logic [LW-1:0]        r_lane_ptr, w_ptr_nx;
    logic [DATA_W-1:0]    r_out_data, w_data_nx, w_emit_data;
    logic [LW-1:0]        r_out_lane, w_lane_nx, w_emit_lane;
    logic                 r_out_valid, w_valid_nx;
    logic                 r_out_idle, w_idle_nx;
    logic                 w_emit, w_fill;

    assign in_ready = !reset && !w_full;
    assign w_push   = (|in_valid) && in_ready;

    phy_tx_word_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({in_valid, in_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_head_mask = '0;
        w_next_mask = '0;
        w_head_mask[NUM_LANES-1:0] = w_head[EW-1 -: NUM_LANES];
        w_next_mask[NUM_LANES-1:0] = w_next[EW-1 -: NUM_LANES];
        for (int i = 0; i < NUM_LANES; i++) begin
            w_head_lane[i] = w_head[i*DATA_W +: DATA_W];
            w_next_lane[i] = w_next[i*DATA_W +: DATA_W];
        end
    end

    assign w_sel_above = next_set_bit(w_head_mask, int'(r_lane_ptr) + 1);
    assign w_sel_head  = next_set_bit(w_head_mask, 0);
    assign w_sel_next  = next_set_bit(w_next_mask, 0);

    // A held symbol (payload or idle) is only replaced once downstream takes it.
    assign w_load = !r_out_valid || out_ready;

    always_comb begin
        w_state_nx  = r_state;
        w_ptr_nx    = r_lane_ptr;
        w_pop       = 1'b0;
        w_data_nx   = r_out_data;
        w_lane_nx   = r_out_lane;
        w_valid_nx  = r_out_valid;
        w_idle_nx   = r_out_idle;
        w_emit      = 1'b0;
        w_fill      = 1'b0;
        w_emit_lane = '0;
        w_emit_data = '0;
        if (w_load) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_emit      = 1'b1;
                        w_emit_lane = LW'(w_sel_head.idx);
                        w_emit_data = w_head_lane[w_emit_lane];
                    end else begin
                        w_fill = 1'b1;
                    end
                end
                ST_SEND: begin
                    if (w_sel_above.found) begin
                        w_emit      = 1'b1;
                        w_emit_lane = LW'(w_sel_above.idx);
                        w_emit_data = w_head_lane[w_emit_lane];
                    end else begin
                        w_pop = 1'b1;
                        if (fifo_count > CW'(1)) begin
                            w_emit      = 1'b1;
                            w_emit_lane = LW'(w_sel_next.idx);
                            w_emit_data = w_next_lane[w_emit_lane];
                        end else begin
                            w_fill = 1'b1;
                        end
                    end
                end
                default: w_fill = 1'b1;
            endcase
            if (w_emit) begin
                w_state_nx = ST_SEND;
                w_ptr_nx   = w_emit_lane;
                w_data_nx  = w_emit_data;
                w_lane_nx  = w_emit_lane;
                w_valid_nx = 1'b1;
                w_idle_nx  = 1'b0;
            end
            if (w_fill) begin
                w_state_nx = ST_IDLE;
                w_data_nx  = idle_en ? IDLE_SYM : '0;
                w_lane_nx  = '0;
                w_valid_nx = idle_en;
                w_idle_nx  = idle_en;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lane_ptr  <= '0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
            r_out_valid <= 1'b0;
            r_out_idle  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_lane_ptr  <= w_ptr_nx;
            r_out_data  <= w_data_nx;
            r_out_lane  <= w_lane_nx;
            r_out_valid <= w_valid_nx;
            r_out_idle  <= w_idle_nx;
        end
    end

    assign out_data  = r_out_data;
    assign out_lane  = r_out_lane;
    assign out_valid = r_out_valid;
    assign out_idle  = r_out_idle;
endmodule
